accum_controller: RTL and testbench

//   Sequencer for the 8-bit accumulate datapath (4-bit A input, sel[1:0] mux, fgt127 flag, F register).

---
 rtl/accum_controller_pkg.sv | 16 +
 rtl/accum_controller_sample_counter.sv | 44 ++++
 rtl/accum_controller.sv | 154 +++++++++++++++
 tb/tb_accum_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_controller_pkg.sv
// Shared definitions for the accumulate sequencer: datapath mux codes and FSM states.
package accum_controller_pkg;

    localparam logic [1:0] SEL_CLEAR = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_ADD   = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CLEAR = 2'b01,
        S_ACCUM = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/accum_controller_sample_counter.sv
// Sample counter with synchronous clear, count enable and a "last sample" flag
// that is high while one more increment would reach MAX_SAMPLES.
module sample_counter #(
    parameter int MAX_SAMPLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX_SAMPLES - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (en) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/accum_controller.sv
// Sequencer for the 8-bit accumulate datapath: clears F, loads the first sample,
// adds the rest, and stops on sample count or imminent overflow.
module accum_controller
    import accum_controller_pkg::*;
#(
    parameter int MAX_SAMPLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             fgt127,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] sample_count
);

    state_e           state_q;
    state_e           state_d;
    logic             done_q;
    logic             done_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_value;

    sample_counter #(
        .MAX_SAMPLES (MAX_SAMPLES),
        .CNT_W       (CNT_W)
    ) u_sample_counter (
        .clock (clock),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_value),
        .last  (cnt_last)
    );

    // Next state, datapath select, handshake and status flag updates.
    always_comb begin
        state_d    = state_q;
        sel        = SEL_HOLD;
        in_ready   = 1'b0;
        busy       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done_d     = done_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    overflow_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (abort) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    sel        = SEL_CLEAR;
                    cnt_clr    = 1'b1;
                    overflow_d = 1'b0;
                    state_d    = S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (abort) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    in_ready = 1'b1;
                    if (!in_valid) begin
                        sel = SEL_HOLD;
                    end else if (cnt_value == {CNT_W{1'b0}}) begin
                        // First sample loads F; fgt127 reflects stale F here.
                        sel    = SEL_LOAD;
                        cnt_en = 1'b1;
                        if (cnt_last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end else if (fgt127) begin
                        // Sample is consumed but dropped so F stays <= 127.
                        sel        = SEL_HOLD;
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        sel    = SEL_ADD;
                        cnt_en = 1'b1;
                        if (cnt_last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                end else if (start) begin
                    state_d    = S_CLEAR;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                done_d     = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
    end

    // State and registered status flags.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign done         = done_q;
    assign overflow     = overflow_q;
    assign sample_count = cnt_value;

endmodule

// File: tb/tb_accum_controller.sv
// Directed bench: two controllers (MAX_SAMPLES=4 and 15), each driving a behavioural
// accumulate datapath whose F register uses an active-low reset tied to ~rst.
module tb_accum_controller;

    logic       clock;
    logic       rst;
    logic       rst_n;

    logic       start_a, abort_a, in_valid_a, in_ready_a, fgt_a, busy_a, done_a, ovf_a;
    logic [3:0] in_data_a;
    logic [1:0] sel_a;
    logic [3:0] cnt_a;
    logic [7:0] f_a;
    logic [7:0] sum_a;

    logic       start_b, abort_b, in_valid_b, in_ready_b, fgt_b, busy_b, done_b, ovf_b;
    logic [3:0] in_data_b;
    logic [1:0] sel_b;
    logic [3:0] cnt_b;
    logic [7:0] f_b;
    logic [7:0] sum_b;

    int errors = 0;
    int checks = 0;

    assign rst_n = ~rst;

    accum_controller #(.MAX_SAMPLES(4), .CNT_W(4)) dut_a (
        .clock(clock), .rst(rst), .start(start_a), .abort(abort_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .fgt127(fgt_a), .sel(sel_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .sample_count(cnt_a)
    );

    accum_controller #(.MAX_SAMPLES(15), .CNT_W(4)) dut_b (
        .clock(clock), .rst(rst), .start(start_b), .abort(abort_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .fgt127(fgt_b), .sel(sel_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .sample_count(cnt_b)
    );

    assign sum_a = f_a + {4'b0000, in_data_a};
    assign fgt_a = sum_a[7];
    assign sum_b = f_b + {4'b0000, in_data_b};
    assign fgt_b = sum_b[7];

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) f_a <= 8'd0;
        else case (sel_a)
            2'b00:   f_a <= 8'd0;
            2'b01:   f_a <= {4'b0000, in_data_a};
            2'b10:   f_a <= sum_a;
            default: f_a <= f_a;
        endcase
    end

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) f_b <= 8'd0;
        else case (sel_b)
            2'b00:   f_b <= 8'd0;
            2'b01:   f_b <= {4'b0000, in_data_b};
            2'b10:   f_b <= sum_b;
            default: f_b <= f_b;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; in_valid_a = 1'b0; in_data_a = 4'd0;
        start_b = 1'b0; abort_b = 1'b0; in_valid_b = 1'b0; in_data_b = 4'd0;
        #1;
        chk("rst_sel", sel_a, 3);
        chk("rst_ready", in_ready_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_cnt", cnt_a, 0);

        // Test 1: stream 3,5,7,9
        tick(); rst = 1'b0; start_a = 1'b1; #1;
        chk("t1_idle_sel", sel_a, 3);
        tick(); start_a = 1'b0; in_valid_a = 1'b1; in_data_a = 4'd3; #1;
        chk("t1_clear_sel", sel_a, 0);
        chk("t1_clear_busy", busy_a, 1);
        chk("t1_clear_ready", in_ready_a, 0);
        tick(); #1;
        chk("t1_load_sel", sel_a, 1);
        chk("t1_accum_ready", in_ready_a, 1);
        tick(); in_data_a = 4'd5; #1;
        chk("t1_add1_sel", sel_a, 2);
        tick(); in_data_a = 4'd7; #1;
        chk("t1_add2_sel", sel_a, 2);
        tick(); in_data_a = 4'd9; #1;
        chk("t1_add3_sel", sel_a, 2);
        chk("t1_done_early", done_a, 0);
        tick(); #1;
        chk("t1_done", done_a, 1);
        chk("t1_f", f_a, 24);
        chk("t1_cnt", cnt_a, 4);
        chk("t1_ovf", ovf_a, 0);
        chk("t1_done_sel", sel_a, 3);
        chk("t1_done_busy", busy_a, 0);
        chk("t1_done_ready", in_ready_a, 0);

        // Test 5a: start and abort together in DONE
        in_valid_a = 1'b0; start_a = 1'b1; abort_a = 1'b1; #1;
        chk("t5_abort_sel", sel_a, 3);
        tick(); start_a = 1'b0; abort_a = 1'b0; #1;
        chk("t5_idle_done", done_a, 0);
        chk("t5_idle_busy", busy_a, 0);
        chk("t5_idle_cnt", cnt_a, 4);

        // Test 4: abort after two samples
        start_a = 1'b1;
        tick(); start_a = 1'b0; in_valid_a = 1'b1; in_data_a = 4'd4;
        tick(); #1;
        chk("t4_load_sel", sel_a, 1);
        tick(); #1;
        chk("t4_add_sel", sel_a, 2);
        tick(); abort_a = 1'b1; #1;
        chk("t4_abort_sel", sel_a, 3);
        chk("t4_abort_ready", in_ready_a, 0);
        tick(); abort_a = 1'b0; in_valid_a = 1'b0; #1;
        chk("t4_idle_done", done_a, 0);
        chk("t4_idle_busy", busy_a, 0);
        chk("t4_f_held", f_a, 8);
        chk("t4_cnt_kept", cnt_a, 2);
        tick(); #1;
        chk("t4_abort_noeffect_busy", busy_a, 0);
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); #1;
        chk("t4_f_cleared", f_a, 0);
        chk("t4_cnt_cleared", cnt_a, 0);
        in_valid_a = 1'b1; in_data_a = 4'd2;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("t4_rejob_done", done_a, 1);
        chk("t4_rejob_f", f_a, 8);

        // Test 5b: start alone in DONE, then Test 3 with a 3-cycle gap
        in_valid_a = 1'b0; start_a = 1'b1;
        tick(); start_a = 1'b0; in_valid_a = 1'b1; in_data_a = 4'd3; #1;
        chk("t5_clear_done", done_a, 0);
        chk("t5_clear_ovf", ovf_a, 0);
        chk("t5_clear_busy", busy_a, 1);
        chk("t5_clear_sel", sel_a, 0);
        tick(); #1;
        chk("t3_load_sel", sel_a, 1);
        tick(); in_data_a = 4'd5; #1;
        chk("t3_add_sel", sel_a, 2);
        for (int i = 0; i < 3; i++) begin
            tick(); in_valid_a = 1'b0; #1;
            chk("t3_gap_sel", sel_a, 3);
            chk("t3_gap_ready", in_ready_a, 1);
        end
        tick(); in_valid_a = 1'b1; in_data_a = 4'd7; #1;
        chk("t3_add7_sel", sel_a, 2);
        tick(); in_data_a = 4'd9; #1;
        chk("t3_not_done", done_a, 0);
        tick(); in_valid_a = 1'b0; #1;
        chk("t3_done", done_a, 1);
        chk("t3_f", f_a, 24);
        chk("t3_cnt", cnt_a, 4);

        // Test 2: MAX_SAMPLES=15, fifteen 15s, overflow on the 9th
        start_b = 1'b1;
        tick(); start_b = 1'b0; in_valid_b = 1'b1; in_data_b = 4'd15;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("t2_sel", sel_b, (i == 0) ? 1 : 2);
        end
        tick(); #1;
        chk("t2_ovf_sel", sel_b, 3);
        chk("t2_ovf_ready", in_ready_b, 1);
        tick(); #1;
        chk("t2_done", done_b, 1);
        chk("t2_ovf", ovf_b, 1);
        chk("t2_f", f_b, 120);
        chk("t2_cnt", cnt_b, 8);
        chk("t2_done_ready", in_ready_b, 0);
        in_valid_b = 1'b0; start_b = 1'b1;
        tick(); start_b = 1'b0; #1;
        chk("t2_restart_ovf", ovf_b, 0);
        chk("t2_restart_done", done_b, 0);
        chk("t2_restart_sel", sel_b, 0);
        tick();

        // Test 6: asynchronous reset mid-ACCUM
        start_a = 1'b1;
        tick(); start_a = 1'b0; in_valid_a = 1'b1; in_data_a = 4'd1;
        tick(); tick(); #1;
        chk("t6_pre_cnt", cnt_a, 1);
        tick(); #2;
        rst = 1'b1; #1;
        chk("t6_sel", sel_a, 3);
        chk("t6_busy", busy_a, 0);
        chk("t6_ready", in_ready_a, 0);
        chk("t6_done", done_a, 0);
        chk("t6_cnt", cnt_a, 0);
        chk("t6_f", f_a, 0);
        chk("t6_b_busy", busy_b, 0);
        tick(); rst = 1'b0;
        tick(); #1;
        chk("t6_after_busy", busy_a, 0);
        chk("t6_after_f", f_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
